// File: rtl/bcd_display_mux_if.sv
// Bus between the counter chain and the display multiplexer: BCD digits and controls in,
// segment/anode drive and current slot index out.
interface bcd_display_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  localparam int unsigned SlotW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] digits;
  logic                  update;
  logic                  blank_lz;
  logic [N_DIGITS-1:0]   dp_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic [SlotW-1:0]      slot;

  modport master (
    output digits, update, blank_lz, dp_en,
    input  seg, dp, an, slot
  );

  modport slave (
    input  digits, update, blank_lz, dp_en,
    output seg, dp, an, slot
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment driver: shadows BCD digits on update, decodes with leading-zero
// blanking, and rotates one digit per refresh slot with a dark first cycle against ghosting.
module bcd_display_mux #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_mux_if.slave   bus
);

  localparam int unsigned SlotW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CntW  = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0]  CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [SlotW-1:0] SlotMax = SlotW'(N_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [N_DIGITS-1:0]   lz;
  logic                  all_zero;
  logic [3:0]            cur;
  logic                  blank;
  logic                  active;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  logic [N_DIGITS-1:0]   an_hi;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    slot_d = slot_q;
    if (cnt_q == CntMax) begin
      slot_d = (slot_q == SlotMax) ? '0 : slot_q + 1'b1;
    end
    shadow_d = bus.update ? bus.digits : shadow_q;

    // lz[k] is set when digit k and every digit above it are zero; invalid codes are nonzero.
    lz       = '0;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (shadow_q[4*k +: 4] == 4'd0);
      lz[k]    = all_zero;
    end

    cur    = shadow_q[4*int'(slot_q) +: 4];
    blank  = bus.blank_lz && lz[slot_q] && (slot_q != '0);
    active = (cnt_q != '0);

    seg_hi = blank ? 7'h00 : decode(cur);
    dp_hi  = active && bus.dp_en[slot_q];
    an_hi  = '0;
    an_hi[slot_q] = active;

    seg_d = seg_hi ^ {7{ACTIVE_LOW}};
    dp_d  = dp_hi ^ ACTIVE_LOW;
    an_d  = an_hi ^ {N_DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      slot_q   <= '0;
      shadow_q <= '0;
      seg_q    <= {7{ACTIVE_LOW}};
      dp_q     <= ACTIVE_LOW;
      an_q     <= {N_DIGITS{ACTIVE_LOW}};
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.an   = an_q;
  assign bus.slot = slot_q;

endmodule
